// File: rtl/chk_pkg.sv
// Shared types and default constants for the DM result checker.
package chk_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  localparam int unsigned DEF_SIM_END    = 32'h0000_3fff;
  localparam int unsigned DEF_TEST_START = 32'h0000_2000;
  localparam logic [63:0] DEF_END_CODE   = '1;

  // Index width for a window of n words, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_result_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins; otherwise count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dm_result_checker.sv
// Snoops the CPU DM write bus for the end sentinel (or times out), halts
// the CPU, then scans a DM window against golden memory and reports.
module dm_result_checker
  import chk_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          TEST_START = DEF_TEST_START,
  parameter int unsigned          TEST_LEN   = 64,
  parameter int unsigned          IDX_W      = idx_width(TEST_LEN),
  parameter int unsigned          SIM_END    = DEF_SIM_END,
  parameter logic [DATA_W-1:0]    END_CODE   = DATA_W'(DEF_END_CODE),
  parameter int unsigned          MAX_CYCLE  = 150000,
  parameter int unsigned          ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_waddr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              chk_re,
  output logic [ADDR_W-1:0] chk_raddr,
  input  logic [DATA_W-1:0] chk_rdata,
  output logic [IDX_W-1:0]  gold_raddr,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic              cpu_halt,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [31:0]       cycle_count,
  output logic              mis_valid,
  output logic [IDX_W-1:0]  mis_index,
  output logic [DATA_W-1:0] mis_data,
  output logic [DATA_W-1:0] mis_expect
);

  chk_state_e       state;
  logic             cmp_valid;
  logic [IDX_W-1:0] cmp_idx;

  logic sentinel_c;
  logic max_hit_c;
  logic last_idx_c;
  logic mismatch_c;
  logic run_c;

  // Decode the end-of-test write, the timeout point and the last scan index.
  always_comb begin
    sentinel_c = dm_we && (dm_waddr == ADDR_W'(SIM_END)) && (dm_wdata == END_CODE);
    max_hit_c  = (cycle_count == 32'(MAX_CYCLE - 1));
    last_idx_c = (gold_raddr == IDX_W'(TEST_LEN - 1));
    mismatch_c = cmp_valid && (chk_rdata !== gold_rdata);
    run_c      = (state == ST_RUN);
  end

  sat_counter #(.W(32)) u_cycle_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (run_c),
    .count (cycle_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (mismatch_c),
    .count (err_count)
  );

  // Control FSM, scan address generator and registered compare stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      chk_re     <= 1'b0;
      chk_raddr  <= '0;
      gold_raddr <= '0;
      cpu_halt   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_idx    <= '0;
      mis_valid  <= 1'b0;
      mis_index  <= '0;
      mis_data   <= '0;
      mis_expect <= '0;
    end else begin
      // Read data arrives one cycle after the request, so compare trails issue.
      cmp_valid <= chk_re;
      cmp_idx   <= gold_raddr;

      if (mismatch_c && !mis_valid) begin
        mis_valid  <= 1'b1;
        mis_index  <= cmp_idx;
        mis_data   <= chk_rdata;
        mis_expect <= gold_rdata;
      end

      case (state)
        ST_RUN: begin
          if (sentinel_c || max_hit_c) begin
            // Sentinel takes priority over a coincident timeout.
            timeout    <= !sentinel_c;
            state      <= ST_SCAN;
            cpu_halt   <= 1'b1;
            chk_re     <= 1'b1;
            chk_raddr  <= ADDR_W'(TEST_START);
            gold_raddr <= '0;
          end
        end
        ST_SCAN: begin
          if (last_idx_c) begin
            state  <= ST_FLUSH;
            chk_re <= 1'b0;
          end else begin
            chk_raddr  <= chk_raddr + ADDR_W'(1);
            gold_raddr <= gold_raddr + IDX_W'(1);
          end
        end
        ST_FLUSH: begin
          // Final compare is still in flight this cycle; fold it into pass.
          state <= ST_DONE;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mismatch_c && !timeout;
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_result_checker.sv
// Randomised bench for dm_result_checker with a behavioural timeline model.
module tb_dm_result_checker;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TS      = 'h2000;
  localparam int unsigned L       = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SIM_END = 'h3fff;
  localparam int unsigned MAXC    = 50;
  localparam int unsigned ERR_W   = 2;
  localparam logic [31:0] ENDC    = 32'hffff_ffff;

  logic              clk;
  logic              rst;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_waddr;
  logic [DATA_W-1:0] dm_wdata;
  logic              chk_re;
  logic [ADDR_W-1:0] chk_raddr;
  logic [DATA_W-1:0] chk_rdata;
  logic [IDX_W-1:0]  gold_raddr;
  logic [DATA_W-1:0] gold_rdata;
  logic              cpu_halt;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [ERR_W-1:0]  err_count;
  logic [31:0]       cycle_count;
  logic              mis_valid;
  logic [IDX_W-1:0]  mis_index;
  logic [DATA_W-1:0] mis_data;
  logic [DATA_W-1:0] mis_expect;

  dm_result_checker #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TEST_START (TS),
    .TEST_LEN   (L),
    .SIM_END    (SIM_END),
    .END_CODE   (ENDC),
    .MAX_CYCLE  (MAXC),
    .ERR_W      (ERR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dm_we       (dm_we),
    .dm_waddr    (dm_waddr),
    .dm_wdata    (dm_wdata),
    .chk_re      (chk_re),
    .chk_raddr   (chk_raddr),
    .chk_rdata   (chk_rdata),
    .gold_raddr  (gold_raddr),
    .gold_rdata  (gold_rdata),
    .cpu_halt    (cpu_halt),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .err_count   (err_count),
    .cycle_count (cycle_count),
    .mis_valid   (mis_valid),
    .mis_index   (mis_index),
    .mis_data    (mis_data),
    .mis_expect  (mis_expect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with a halt-gated CPU write port, a preload port and the
  // secondary read port; golden memory shares the read timing.
  logic [31:0] dm_mem [0:65535];
  logic [31:0] gold   [0:L-1];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) dm_mem[pre_addr] <= pre_data;
    else if (dm_we && !cpu_halt) dm_mem[dm_waddr] <= dm_wdata;
    if (chk_re) begin
      chk_rdata  <= dm_mem[chk_raddr];
      gold_rdata <= gold[gold_raddr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle index since the last reset edge; cycle n follows edge n.
  int n = 0;
  bit chk_on = 1'b0;
  always @(posedge clk) n <= rst ? 0 : n + 1;

  // Model: the scan begins at edge E; everything else follows from E and
  // a snapshot of the window taken once the CPU is frozen.
  int          E = 1;
  bit          exp_to = 1'b0;
  bit          bad [L];
  logic [31:0] snap [L];
  int          nbad = 0;
  int          first_bad = -1;

  int  m_cc, m_scanned, m_err;
  bit  m_halt, m_re, m_done, m_mv;

  always @(negedge clk) begin
    if (chk_on) begin
      if (n == E) begin
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < int'(L); i++) begin
          snap[i] = dm_mem[TS + i];
          bad[i]  = (snap[i] != gold[i]);
          if (bad[i]) begin
            nbad++;
            if (first_bad < 0) first_bad = i;
          end
        end
      end
      m_halt = (n >= E);
      m_re   = (n >= E) && (n < E + int'(L));
      m_done = (n >= E + int'(L) + 1);
      m_cc   = (n < E) ? n : E;
      m_scanned = n - E - 1;
      if (m_scanned < 0) m_scanned = 0;
      if (m_scanned > int'(L)) m_scanned = L;
      m_err = 0;
      for (int i = 0; i < m_scanned; i++) if (bad[i]) m_err++;
      if (m_err > 3) m_err = 3;
      m_mv = (first_bad >= 0) && (n >= E + first_bad + 2);

      chk("cpu_halt", 64'(cpu_halt), 64'(m_halt));
      chk("chk_re", 64'(chk_re), 64'(m_re));
      chk("done", 64'(done), 64'(m_done));
      chk("pass", 64'(pass), 64'(m_done && nbad == 0 && !exp_to));
      chk("timeout", 64'(timeout), 64'(exp_to && m_halt));
      chk("cycle_count", 64'(cycle_count), 64'(m_cc));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("mis_valid", 64'(mis_valid), 64'(m_mv));
      if (m_re) begin
        chk("gold_raddr", 64'(gold_raddr), 64'(n - E));
        chk("chk_raddr", 64'(chk_raddr), 64'(TS + n - E));
      end
      if (n == 0) begin
        chk("rst_gold_raddr", 64'(gold_raddr), 64'd0);
        chk("rst_chk_raddr", 64'(chk_raddr), 64'd0);
        chk("rst_mis_index", 64'(mis_index), 64'd0);
      end
      if (m_mv) begin
        chk("mis_index", 64'(mis_index), 64'(first_bad));
        chk("mis_data", 64'(mis_data), 64'(snap[first_bad]));
        chk("mis_expect", 64'(mis_expect), 64'(gold[first_bad]));
      end
    end
  end

  // CPU-side write for edge c: sentinel at k, a non-END write to the
  // sentinel address at edge 3, random traffic otherwise (sentinels
  // included once the CPU should be frozen).
  task automatic drive(input int c, input int k, input int wpct);
    logic [15:0] a;
    logic [31:0] d;
    dm_we = 1'b0;
    if (c == k) begin
      dm_we = 1'b1; dm_waddr = 16'(SIM_END); dm_wdata = ENDC;
    end else if (c == 3 && c < E) begin
      dm_we = 1'b1; dm_waddr = 16'(SIM_END); dm_wdata = 32'h0;
    end else if (int'($urandom_range(99)) < wpct) begin
      case ($urandom_range(3))
        0, 3:    a = 16'(TS - 2 + $urandom_range(L + 3));
        1:       a = 16'(SIM_END);
        default: a = 16'($urandom);
      endcase
      d = $urandom;
      if (c <= E && a == 16'(SIM_END) && d == ENDC) d = 32'h0;
      if (c > E && $urandom_range(3) == 0) begin
        a = 16'(SIM_END); d = ENDC;
      end
      dm_we = 1'b1; dm_waddr = a; dm_wdata = d;
    end
  endtask

  // mode: 0 window==golden(1..8), 1 'hDEAD at index 2, 2 all inverted, 3 random.
  task automatic scenario(input int k, input int mode, input int wpct,
                          input int abort_at, output bit aborted);
    rst = 1'b1; dm_we = 1'b0; dm_waddr = '0; dm_wdata = '0;
    @(posedge clk); #1;
    E = (k >= 1 && k <= int'(MAXC)) ? k : int'(MAXC);
    exp_to = !(k >= 1 && k <= int'(MAXC));
    for (int i = 0; i < int'(L); i++) gold[i] = (mode == 3) ? $urandom : 32'(i + 1);
    for (int i = 0; i < int'(L); i++) begin
      pre_we = 1'b1;
      pre_addr = 16'(TS + i);
      case (mode)
        1:       pre_data = (i == 2) ? 32'hDEAD : gold[i];
        2:       pre_data = ~gold[i];
        3:       pre_data = ($urandom_range(1) == 0) ? gold[i] : $urandom;
        default: pre_data = gold[i];
      endcase
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    rst = 1'b0;
    aborted = 1'b0;
    for (int c = 1; c <= E + int'(L) + 4; c++) begin
      drive(c, k, wpct);
      if (abort_at != 0 && c == E + abort_at) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    dm_we = 1'b0;
  endtask

  bit ab;
  int rk;

  initial begin
    rst = 1'b1; dm_we = 1'b0; dm_waddr = '0; dm_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;

    // Clean run, sentinel at RUN cycle 20.
    scenario(20, 0, 0, 0, ab);
    chk("lit_clean_cycles", 64'(cycle_count), 64'd20);
    chk("lit_clean_pass", 64'(pass), 64'd1);
    chk("lit_clean_err", 64'(err_count), 64'd0);

    // One corrupted word at index 2.
    scenario(30, 1, 0, 0, ab);
    chk("lit_dead_pass", 64'(pass), 64'd0);
    chk("lit_dead_err", 64'(err_count), 64'd1);
    chk("lit_dead_index", 64'(mis_index), 64'd2);
    chk("lit_dead_data", 64'(mis_data), 64'hDEAD);
    chk("lit_dead_expect", 64'(mis_expect), 64'd3);

    // No sentinel: timeout at cycle 50, scan still completes.
    scenario(0, 0, 0, 0, ab);
    chk("lit_to_flag", 64'(timeout), 64'd1);
    chk("lit_to_cycles", 64'(cycle_count), 64'd50);
    chk("lit_to_done", 64'(done), 64'd1);
    chk("lit_to_pass", 64'(pass), 64'd0);

    // Sentinel coincides with the timeout point: sentinel wins.
    scenario(int'(MAXC), 0, 0, 0, ab);
    chk("lit_race_to", 64'(timeout), 64'd0);
    chk("lit_race_pass", 64'(pass), 64'd1);

    // Every word wrong: error counter saturates at 3.
    scenario(10, 2, 0, 0, ab);
    chk("lit_sat_err", 64'(err_count), 64'd3);
    chk("lit_sat_index", 64'(mis_index), 64'd0);

    // Reset in the middle of the scan, then a normal run.
    scenario(12, 1, 0, 4, ab);
    chk("lit_abort_seen", 64'(ab), 64'd1);
    chk("lit_abort_re", 64'(chk_re), 64'd0);
    chk("lit_abort_cycles", 64'(cycle_count), 64'd0);
    chk("lit_abort_err", 64'(err_count), 64'd0);
    chk("lit_abort_halt", 64'(cpu_halt), 64'd0);
    scenario(15, 0, 0, 0, ab);
    chk("lit_resend_pass", 64'(pass), 64'd1);
    chk("lit_resend_cycles", 64'(cycle_count), 64'd15);

    // Randomised runs with CPU traffic into and around the window.
    for (int s = 0; s < 30; s++) begin
      rk = int'($urandom_range(5, 56));
      if (rk > int'(MAXC)) rk = 0;
      scenario(rk, 3, int'($urandom_range(10, 60)),
               ($urandom_range(7) == 0) ? int'($urandom_range(1, L + 1)) : 0, ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
